// File: rtl/allstep_regbank_pkg.sv
// Shared definitions for the ALLSTEP AXI4-Lite register bank:
// AXI response codes, channel FSM states and an address-width helper.
package allstep_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  // Ceiling log2, used to derive the byte-offset width of an address
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/allstep_regbank_decode.sv
// Register index classifier: RW control, RO status or unmapped.
module allstep_regbank_decode
  import allstep_regbank_pkg::*;
#(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned NUM_RW = 4,
  parameter int unsigned NUM_RO = 4
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_is_rw,
  output logic             o_is_ro,
  output logic             o_is_unmapped
);

  logic [31:0] w_idx;

  // RW registers occupy the lowest indices, RO status follows directly
  always_comb begin
    w_idx         = 32'(i_idx);
    o_is_rw       = (w_idx < NUM_RW);
    o_is_ro       = !o_is_rw && (w_idx < (NUM_RW + NUM_RO));
    o_is_unmapped = !(o_is_rw || o_is_ro);
  end

endmodule

// File: rtl/allstep_axil_regbank.sv
// ALLSTEP AXI4-Lite slave register bank: NUM_RW byte-strobed control
// registers, NUM_RO status registers, decoded error responses and
// per-register write/read pulses for the stepper/PWM datapath.
// Optional macro ALLSTEP_REG_SHADOW_EN: AXI writes land in a shadow copy
// and ctrl_o loads all shadows together when commit_i is seen.
module allstep_axil_regbank
  import allstep_regbank_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 6,
  parameter int unsigned       NUM_RW    = 4,
  parameter int unsigned       NUM_RO    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_RW*DATA_W-1:0]   ctrl_o,
  output logic [NUM_RW-1:0]          wr_pulse_o,
  input  logic [NUM_RO*DATA_W-1:0]   stat_i,
  output logic [NUM_RO-1:0]          rd_pulse_o,
  input  logic                       commit_i
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned ADDR_LSB = clog2(STRB_W);
  localparam int unsigned IDX_W    = ADDR_W - ADDR_LSB;

  if ((DATA_W != 32) && (DATA_W != 64)) begin : g_bad_data_w
    $error("allstep_axil_regbank: DATA_W must be 32 or 64");
  end
  if ((NUM_RW + NUM_RO) > (32'd1 << IDX_W)) begin : g_bad_map
    $error("allstep_axil_regbank: NUM_RW+NUM_RO exceeds the address space");
  end

  // Write channel state
  w_state_t           r_wstate;
  logic               r_awready;
  logic               r_wready;
  logic               r_bvalid;
  logic [1:0]         r_bresp;
  logic               r_aw_done;
  logic               r_w_done;
  logic [IDX_W-1:0]   r_aw_idx;
  logic [DATA_W-1:0]  r_wdata;
  logic [STRB_W-1:0]  r_wstrb;
  logic [NUM_RW-1:0]  r_wr_pulse;
  logic [DATA_W-1:0]  r_regs [NUM_RW];

  // Read channel state
  r_state_t           r_rstate;
  logic               r_arready;
  logic               r_rvalid;
  logic [1:0]         r_rresp;
  logic [DATA_W-1:0]  r_rdata;
  logic [NUM_RO-1:0]  r_rd_pulse;

  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_wr_commit;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [DATA_W-1:0]  w_wr_data;
  logic [STRB_W-1:0]  w_wr_strb;
  logic               w_wr_is_rw;
  logic               w_wr_is_ro;
  logic               w_wr_is_unmapped;
  logic               w_ar_hs;
  logic [IDX_W-1:0]   w_rd_idx;
  logic               w_rd_is_rw;
  logic               w_rd_is_ro;
  logic               w_rd_is_unmapped;
  logic [DATA_W-1:0]  w_rd_val;
  logic               w_unused_addr;

  assign w_unused_addr = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Merge latched and same-cycle AW/W so a write commits on the edge that completes it
  always_comb begin
    w_aw_hs     = r_awready && S_AXI_AWVALID;
    w_w_hs      = r_wready && S_AXI_WVALID;
    w_wr_commit = (r_wstate == W_IDLE) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    w_wr_idx    = r_aw_done ? r_aw_idx : S_AXI_AWADDR[ADDR_W-1:ADDR_LSB];
    w_wr_data   = r_w_done ? r_wdata : S_AXI_WDATA;
    w_wr_strb   = r_w_done ? r_wstrb : S_AXI_WSTRB;
    w_ar_hs     = r_arready && S_AXI_ARVALID;
    w_rd_idx    = S_AXI_ARADDR[ADDR_W-1:ADDR_LSB];
  end

  allstep_regbank_decode #(
    .IDX_W  (IDX_W),
    .NUM_RW (NUM_RW),
    .NUM_RO (NUM_RO)
  ) u_wr_decode (
    .i_idx         (w_wr_idx),
    .o_is_rw       (w_wr_is_rw),
    .o_is_ro       (w_wr_is_ro),
    .o_is_unmapped (w_wr_is_unmapped)
  );

  allstep_regbank_decode #(
    .IDX_W  (IDX_W),
    .NUM_RW (NUM_RW),
    .NUM_RO (NUM_RO)
  ) u_rd_decode (
    .i_idx         (w_rd_idx),
    .o_is_rw       (w_rd_is_rw),
    .o_is_ro       (w_rd_is_ro),
    .o_is_unmapped (w_rd_is_unmapped)
  );

  // Write FSM: collect AW and W in any order, then hold B until accepted
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_done <= 1'b1;
            r_aw_idx  <= S_AXI_AWADDR[ADDR_W-1:ADDR_LSB];
          end
          if (w_w_hs) begin
            r_w_done <= 1'b1;
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
          end
          if (w_wr_commit) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_is_unmapped ? RESP_DECERR :
                         (w_wr_is_ro ? RESP_SLVERR : RESP_OKAY);
          end else begin
            r_awready <= !(r_aw_done || w_aw_hs);
            r_wready  <= !(r_w_done || w_w_hs);
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
      endcase
    end
  end

  // RW register array (the shadow copy when shadowing is enabled) and write pulses
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < NUM_RW; i++) r_regs[i] <= RESET_VAL;
      r_wr_pulse <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        r_wr_pulse[i] <= w_wr_commit && w_wr_is_rw && (w_wr_idx == IDX_W'(i));
        if (w_wr_commit && w_wr_is_rw && (w_wr_idx == IDX_W'(i))) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (w_wr_strb[b]) r_regs[i][b*8 +: 8] <= w_wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

`ifdef ALLSTEP_REG_SHADOW_EN
  logic [DATA_W-1:0] r_ctrl [NUM_RW];

  // Live control copy: all shadows transfer together on commit
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < NUM_RW; i++) r_ctrl[i] <= RESET_VAL;
    end else if (commit_i) begin
      for (int unsigned i = 0; i < NUM_RW; i++) r_ctrl[i] <= r_regs[i];
    end
  end

  // Flatten live control registers onto ctrl_o
  always_comb begin
    ctrl_o = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) ctrl_o[i*DATA_W +: DATA_W] = r_ctrl[i];
  end
`else
  logic w_unused_commit;
  assign w_unused_commit = commit_i;

  // Flatten RW registers directly onto ctrl_o
  always_comb begin
    ctrl_o = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) ctrl_o[i*DATA_W +: DATA_W] = r_regs[i];
  end
`endif

  // Read data mux; unmapped indices read as zero
  always_comb begin
    w_rd_val = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (w_rd_is_rw && (w_rd_idx == IDX_W'(i))) w_rd_val = r_regs[i];
    end
    for (int unsigned j = 0; j < NUM_RO; j++) begin
      if (w_rd_is_ro && (w_rd_idx == IDX_W'(NUM_RW + j))) w_rd_val = stat_i[j*DATA_W +: DATA_W];
    end
  end

  // Read FSM: capture data at AR acceptance, hold R until accepted
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate   <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
      r_rd_pulse <= '0;
    end else begin
      r_rd_pulse <= '0;
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_RESP;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_val;
            r_rresp   <= w_rd_is_unmapped ? RESP_DECERR : RESP_OKAY;
            for (int unsigned j = 0; j < NUM_RO; j++) begin
              r_rd_pulse[j] <= w_rd_is_ro && (w_rd_idx == IDX_W'(NUM_RW + j));
            end
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign wr_pulse_o    = r_wr_pulse;
  assign rd_pulse_o    = r_rd_pulse;

endmodule

// File: tb/tb_allstep_axil_regbank.sv
// Directed bench for allstep_axil_regbank (DATA_W=32, 4 RW + 4 RO registers).
// Honours ALLSTEP_REG_SHADOW_EN when the design is built with it.
module tb_allstep_axil_regbank;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [5:0]   S_AXI_AWADDR;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [5:0]   S_AXI_ARADDR;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] ctrl_o;
  logic [3:0]   wr_pulse_o;
  logic [127:0] stat_i;
  logic [3:0]   rd_pulse_o;
  logic         commit_i;

  allstep_axil_regbank #(
    .DATA_W    (32),
    .ADDR_W    (6),
    .NUM_RW    (4),
    .NUM_RO    (4),
    .RESET_VAL (32'h0)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .ctrl_o        (ctrl_o),
    .wr_pulse_o    (wr_pulse_o),
    .stat_i        (stat_i),
    .rd_pulse_o    (rd_pulse_o),
    .commit_i      (commit_i)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;
  int wr_cnt [4] = '{default: 0};
  int rd_cnt [4] = '{default: 0};
  logic [31:0] exp_reg  [4] = '{default: 32'h0};
  logic [31:0] exp_ctrl [4] = '{default: 32'h0};
  logic [31:0] rd_d;
  logic [1:0]  rsp;

  // Count cycles each pulse output is high, sampled mid-cycle
  always @(negedge ACLK) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_pulse_o[i] === 1'b1) wr_cnt[i]++;
      if (rd_pulse_o[i] === 1'b1) rd_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected readback; the live control copy follows unless shadowing defers it
  task automatic set_exp(input int idx, input logic [31:0] v);
    exp_reg[idx] = v;
`ifndef ALLSTEP_REG_SHADOW_EN
    exp_ctrl[idx] = v;
`endif
  endtask

  task automatic commit_model();
`ifdef ALLSTEP_REG_SHADOW_EN
    for (int i = 0; i < 4; i++) exp_ctrl[i] = exp_reg[i];
`endif
  endtask

  task automatic chk_ctrl(input string tag);
    for (int i = 0; i < 4; i++) check(tag, 64'(ctrl_o[i*32 +: 32]), 64'(exp_ctrl[i]));
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    logic aw_ok, w_ok, aw_now, w_now;
    int n;
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0; n = 0;
    while (!(aw_ok && w_ok) && n < 20) begin
      aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
      w_now  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_now) begin S_AXI_AWVALID = 1'b0; aw_ok = 1'b1; end
      if (w_now)  begin S_AXI_WVALID = 1'b0;  w_ok = 1'b1;  end
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    if (!S_AXI_BVALID) begin
      check("wr_timeout", 64'd0, 64'd1);
      resp = 2'b01;
    end else begin
      resp = S_AXI_BRESP;
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic ok, now;
    int n;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 20) begin
      now = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (now) begin S_AXI_ARVALID = 1'b0; ok = 1'b1; end
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    if (!S_AXI_RVALID) begin
      check("rd_timeout", 64'd0, 64'd1);
      d = 32'hXXXX_XXXX; resp = 2'b01;
    end else begin
      d = S_AXI_RDATA; resp = S_AXI_RRESP;
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    commit_i = 1'b0;
    stat_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
    repeat (3) @(posedge ACLK);
    #1;

    // reset state
    check("rst_awready", 64'(S_AXI_AWREADY), 64'd0);
    check("rst_wready",  64'(S_AXI_WREADY),  64'd0);
    check("rst_bvalid",  64'(S_AXI_BVALID),  64'd0);
    check("rst_arready", 64'(S_AXI_ARREADY), 64'd0);
    check("rst_rvalid",  64'(S_AXI_RVALID),  64'd0);
    check("rst_rdata",   64'(S_AXI_RDATA),   64'd0);
    chk_ctrl("rst_ctrl");
    ARESET = 1'b0;

    // 1: read after reset
    axi_read(6'h00, rd_d, rsp);
    check("t1_rdata", 64'(rd_d), 64'd0);
    check("t1_rresp", 64'(rsp), 64'd0);

    // 2: write 1..4 and read back
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(i * 4), 32'(i + 1), 4'hF, rsp);
      check("t2_bresp", 64'(rsp), 64'd0);
      set_exp(i, 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(i * 4), rd_d, rsp);
      check("t2_rdata", 64'(rd_d), 64'(i + 1));
      check("t2_rresp", 64'(rsp), 64'd0);
      check("t2_wr_pulse", 64'(wr_cnt[i]), 64'd1);
    end
    chk_ctrl("t2_ctrl");

    // 3: byte strobe 0010 on register 1 (holds 2)
    axi_write(6'h04, 32'hAABB_CCDD, 4'b0010, rsp);
    check("t3_bresp", 64'(rsp), 64'd0);
    set_exp(1, 32'h0000_CC02);
    axi_read(6'h04, rd_d, rsp);
    check("t3_rdata", 64'(rd_d), 64'h0000_CC02);
    chk_ctrl("t3_ctrl");

    // 4: W three cycles ahead of AW, BREADY held low for five cycles
    S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    check("t4_wready_pre", 64'(S_AXI_WREADY), 64'd1);
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    repeat (2) begin
      check("t4_wready_held", 64'(S_AXI_WREADY), 64'd0);
      check("t4_bvalid_early", 64'(S_AXI_BVALID), 64'd0);
      @(posedge ACLK); #1;
    end
    S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
    check("t4_awready_pre", 64'(S_AXI_AWREADY), 64'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    set_exp(2, 32'h1234_5678);
    check("t4_bvalid_rise", 64'(S_AXI_BVALID), 64'd1);
    check("t4_bresp", 64'(S_AXI_BRESP), 64'd0);
    chk_ctrl("t4_ctrl");
    for (int k = 0; k < 5; k++) begin
      check("t4_bvalid_hold", 64'(S_AXI_BVALID), 64'd1);
      check("t4_awready_low", 64'(S_AXI_AWREADY), 64'd0);
      check("t4_wready_low", 64'(S_AXI_WREADY), 64'd0);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    check("t4_bvalid_drop", 64'(S_AXI_BVALID), 64'd0);
    check("t4_awready_back", 64'(S_AXI_AWREADY), 64'd1);
    check("t4_wready_back", 64'(S_AXI_WREADY), 64'd1);
    check("t4_wr_pulse", 64'(wr_cnt[2]), 64'd2);

    // 5: error and RO paths
    axi_write(6'h10, 32'hFFFF_FFFF, 4'hF, rsp);
    check("t5_ro_bresp", 64'(rsp), 64'h2);
    axi_write(6'h20, 32'hFFFF_FFFF, 4'hF, rsp);
    check("t5_unmap_bresp", 64'(rsp), 64'h3);
    chk_ctrl("t5_ctrl");
    check("t5_wr_pulse0", 64'(wr_cnt[0]), 64'd1);
    check("t5_wr_pulse3", 64'(wr_cnt[3]), 64'd1);
    axi_read(6'h10, rd_d, rsp);
    check("t5_ro0_rdata", 64'(rd_d), 64'hDEAD_BEEF);
    check("t5_ro0_rresp", 64'(rsp), 64'd0);
    check("t5_rd_pulse0", 64'(rd_cnt[0]), 64'd1);
    axi_read(6'h1C, rd_d, rsp);
    check("t5_ro3_rdata", 64'(rd_d), 64'h4444_4444);
    check("t5_rd_pulse3", 64'(rd_cnt[3]), 64'd1);
    check("t5_rd_pulse1", 64'(rd_cnt[1]), 64'd0);
    axi_read(6'h20, rd_d, rsp);
    check("t5_unmap_rdata", 64'(rd_d), 64'd0);
    check("t5_unmap_rresp", 64'(rsp), 64'h3);
    axi_read(6'h06, rd_d, rsp);
    check("t5_lowbits_rdata", 64'(rd_d), 64'h0000_CC02);

    // WSTRB=0: acknowledged, no change, pulse still fires
    axi_write(6'h0C, 32'hFFFF_FFFF, 4'h0, rsp);
    check("t5_strb0_bresp", 64'(rsp), 64'd0);
    axi_read(6'h0C, rd_d, rsp);
    check("t5_strb0_rdata", 64'(rd_d), 64'd4);
    check("t5_strb0_pulse", 64'(wr_cnt[3]), 64'd2);

    // 6: commit behaviour (shadow load, or no effect without shadowing)
    axi_write(6'h00, 32'h0000_0055, 4'hF, rsp);
    set_exp(0, 32'h0000_0055);
    axi_read(6'h00, rd_d, rsp);
    check("t6_rdata", 64'(rd_d), 64'h55);
    chk_ctrl("t6_ctrl_pre");
    commit_i = 1'b1;
    @(posedge ACLK); #1;
    commit_i = 1'b0;
    commit_model();
    chk_ctrl("t6_ctrl_post");

    // reset mid-run clears the registers and the handshakes
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    for (int i = 0; i < 4; i++) begin exp_reg[i] = 32'h0; exp_ctrl[i] = 32'h0; end
    chk_ctrl("rst2_ctrl");
    check("rst2_awready", 64'(S_AXI_AWREADY), 64'd0);
    ARESET = 1'b0;
    axi_read(6'h08, rd_d, rsp);
    check("rst2_rdata", 64'(rd_d), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/allstep_axil_regbank.md
Name: allstep_axil_regbank

Overview:
Parametrised AXI4-Lite slave register bank for the ALLSTEP motor-control cores. It replaces the fixed 4 x 32-bit slave-register block with:
- configurable data width and counts of read/write (RW) control and read-only (RO) status registers;
- byte strobes;
- decoded error responses;
- per-register write and read strobes for downstream logic.

It sits between the PS AXI interconnect and the stepper/PWM datapath.

Parameters:
DATA_W, 32, AXI data width; legal values 32 or 64.
ADDR_W, 6, AXI address width.
NUM_RW, 4, number of RW control registers.
NUM_RO, 4, number of RO status registers.
RESET_VAL, 0, reset value of every RW register.

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous reset, active-high
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake
S_AXI_WDATA  in  DATA_W  write data
S_AXI_WSTRB  in  DATA_W/8  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake
S_AXI_RDATA  out  DATA_W  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake
ctrl_o  out  NUM_RW*DATA_W  RW register contents; register i in slice i
wr_pulse_o  out  NUM_RW  one-cycle pulse per RW register written
stat_i  in  NUM_RO*DATA_W  RO status values
rd_pulse_o  out  NUM_RO  one-cycle pulse per RO register read (clear-on-read hooks)
commit_i  in  1  shadow commit strobe; used only with the optional feature

Behaviour:
- Address decode:
  - ADDR_LSB = log2(DATA_W/8); idx = addr[ADDR_W-1:ADDR_LSB].
  - idx < NUM_RW: RW register.
  - NUM_RW <= idx < NUM_RW+NUM_RO: RO register.
  - Otherwise: unmapped.
  - Low address bits are ignored. AWPROT/ARPROT are not ports.
  - NUM_RW+NUM_RO > 2**(ADDR_W-ADDR_LSB) is an elaboration error.
- Reset (synchronous, ARESET=1 at a rising edge):
  - All READY/VALID outputs 0; BRESP, RRESP, RDATA = 0.
  - ctrl_o = RESET_VAL; pulses 0.
  - Any in-flight transaction is dropped. The master must restart after reset.
- Write FSM, states W_IDLE and W_RESP; one outstanding write at a time:
  - W_IDLE: AWREADY=1 until AW is latched; WREADY=1 until W is latched. AW and W are accepted in either order or in the same cycle.
  - At the edge after both are latched:
    - RW target: update bytes enabled by WSTRB; wr_pulse_o[idx]=1 for one cycle; BRESP=OKAY (00).
    - RO target: no state change; BRESP=SLVERR (10).
    - Unmapped target: no state change; BRESP=DECERR (11).
    - BVALID=1; go to W_RESP.
  - W_RESP: AWREADY=WREADY=0. Hold BVALID/BRESP until BREADY. On the handshake, go to W_IDLE; AWREADY/WREADY reassert the next cycle.
  - Minimum write latency: handshake cycle N -> BVALID and updated ctrl_o at N+1.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: ARREADY=1. On the handshake at edge N:
    - RDATA registered at N: RW value, stat_i slice, or 0 for unmapped.
    - RRESP = OKAY for mapped addresses, DECERR for unmapped.
    - RVALID=1 from N+1.
    - rd_pulse_o[idx-NUM_RW]=1 for one cycle on an RO read.
  - R_RESP: ARREADY=0. Hold RDATA/RRESP stable until RREADY, then go to R_IDLE.
- Simultaneous read and write: channels are independent. A read of a register whose write commits in the same cycle returns the pre-write value. RO stat_i is sampled once, at AR acceptance.
- WSTRB=0: the write is acknowledged OKAY, no data changes, and wr_pulse_o still fires.

Optional Feature:
Macro ALLSTEP_REG_SHADOW_EN.
- Defined:
  - AXI writes update a shadow copy. Reads return the shadow.
  - ctrl_o loads all shadows simultaneously on the edge after commit_i=1.
  - A write and a commit in the same cycle: the commit takes the pre-write shadow.
  - Reset clears both the shadow and ctrl_o to RESET_VAL.
- Not defined: no shadow; ctrl_o updates directly; commit_i is ignored.

Decomposition:
- Package allstep_regbank_pkg holds:
  - AXI response constants RESP_OKAY / RESP_SLVERR / RESP_DECERR;
  - FSM state enums (w_state_t, r_state_t);
  - function clog2 for ADDR_LSB.
- One sub-module, allstep_regbank_decode: combinational idx classification (is_rw, is_ro, is_unmapped), instantiated for the write and read paths.

Test Plan:
1. Reset, then read 0x00 -> RDATA=0x00000000, RRESP=00.
2. Write 0x1..0x4 to 0x00/0x04/0x08/0x0C, then read back -> each value returned with OKAY; wr_pulse_o bits 0..3 each high exactly one cycle.
3. Register 0x04 holds 0x00000002; write 0xAABBCCDD with WSTRB=0010 -> read returns 0x0000CC02.
4. W valid 3 cycles before AW, with BREADY held low 5 cycles:
   - BVALID rises the cycle after AW acceptance and stays high;
   - AWREADY/WREADY stay 0 until the B handshake.
5. Error and RO paths:
   - Write to 0x10 -> BRESP=10, ctrl_o unchanged.
   - Read 0x10 with stat_i[0]=0xDEADBEEF -> that value, RRESP=00, rd_pulse_o[0] pulses once.
   - Read 0x20 -> RDATA=0, RRESP=11.
6. With ALLSTEP_REG_SHADOW_EN: write 0x55 to 0x00 -> read returns 0x55 while ctrl_o[31:0] stays 0; pulse commit_i -> ctrl_o[31:0]=0x55 the next cycle.
